// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: mode encodings,
// FSM state type and the bit-counter width helper.
package serial_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  // A word of w bits needs a counter that can index bits 0..w-1.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational one-bit full adder used as the serial datapath cell.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor, LSB first, with word framing and stall support.
// Optional macro SERIAL_ADDSUB_SAT_EN saturates the parallel result on signed overflow.
module serial_addsub
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             in_valid,
  input  logic             in1,
  input  logic             in2,
  output logic             sum_bit,
  output logic             sum_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic               sum_bit_q, sum_bit_d;
  logic               sum_valid_q, sum_valid_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               accept_start;
  logic               accept_run;
  logic               accept;
  logic               last_bit;
  logic               cur_mode;
  logic               c_in;
  logic               b_eff;
  logic               s_bit;
  logic               c_next;
  logic               ovf_now;
  logic [WIDTH-1:0]   sr_next;

  assign accept_start = (state_q == ST_IDLE) && start && in_valid;
  assign accept_run   = (state_q == ST_RUN) && in_valid;
  assign accept       = accept_start || accept_run;
  assign last_bit     = accept_run && (cnt_q == CNT_W'(WIDTH - 1));

  // The start cycle sees the freshly sampled mode, which also seeds carry-in
  // (subtraction adds the inverted operand plus one).
  assign cur_mode = accept_start ? sub : mode_q;
  assign c_in     = accept_start ? sub : carry_q;
  assign b_eff    = in2 ^ (cur_mode == MODE_SUB);

  fa_cell u_fa (
    .a    (in1),
    .b    (b_eff),
    .cin  (c_in),
    .s    (s_bit),
    .cout (c_next)
  );

  assign sr_next = {s_bit, sr_q[WIDTH-1:1]};
  assign ovf_now = c_in ^ c_next;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    sum_bit_d   = sum_bit_q;
    sum_valid_d = 1'b0;
    done_d      = 1'b0;
    result_d    = result_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;

    if (accept) begin
      carry_d     = c_next;
      cnt_d       = cnt_q + CNT_W'(1);
      sr_d        = sr_next;
      sum_bit_d   = s_bit;
      sum_valid_d = 1'b1;
    end

    if (accept_start) begin
      state_d = ST_RUN;
      mode_d  = sub;
    end

    if (last_bit) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      done_d   = 1'b1;
      cout_d   = c_next;
      ovf_d    = ovf_now;
      result_d = sr_next;
`ifdef SERIAL_ADDSUB_SAT_EN
      // in1 here is operand A's sign bit, which decides the saturation direction.
      if (ovf_now) begin
        result_d = in1 ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_ADD;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sr_q        <= '0;
      sum_bit_q   <= 1'b0;
      sum_valid_q <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      sum_bit_q   <= sum_bit_d;
      sum_valid_q <= sum_valid_d;
      done_q      <= done_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign sum_bit   = sum_bit_q;
  assign sum_valid = sum_valid_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: expected bits and words are queued as
// operands are driven and popped as the DUT emits sum bits and done pulses.
module tb_serial_addsub;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         o;
    int           cyc;
  } word_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic         in_valid;
  logic         in1;
  logic         in2;
  logic         sum_bit;
  logic         sum_valid;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int    total;
  int    bad;
  int    cyc;
  int    n_words;
  int    n_done;
  word_t wq[$];
  logic  bq[$];

  serial_addsub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .in_valid  (in_valid),
    .in1       (in1),
    .in2       (in2),
    .sum_bit   (sum_bit),
    .sum_valid (sum_valid),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: pops expected bits on sum_valid and expected words on done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sum_valid) begin
        if (bq.size() == 0) checkOutput("spurious_sum_valid", {31'd0, sum_valid}, 32'd0);
        else checkOutput("sum_bit", {31'd0, sum_bit}, {31'd0, bq.pop_front()});
      end
      if (done) begin
        n_done++;
        if (wq.size() == 0) begin
          checkOutput("spurious_done", {31'd0, done}, 32'd0);
        end else begin
          word_t w;
          w = wq.pop_front();
          checkOutput("result", {24'd0, result}, {24'd0, w.res});
          checkOutput("cout", {31'd0, cout}, {31'd0, w.c});
          checkOutput("ovf", {31'd0, ovf}, {31'd0, w.o});
          checkOutput("done_cycle", cyc, w.cyc);
        end
      end
    end
  end

  // Drives one word; stall_at/stall_len insert in_valid gaps, midstart
  // re-asserts start at bit 4, abort_at pulses reset before that bit lands.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                               input int stall_at, input int stall_len, input bit midstart,
                               input int abort_at);
    word_t        w;
    logic [W:0]   full;
    logic [W-1:0] wrapped;
    full    = {1'b0, a} + (s ? ({1'b0, ~b} + 1'b1) : {1'b0, b});
    wrapped = full[W-1:0];
    w.c     = full[W];
    if (s) w.o = (a[W-1] != b[W-1]) && (wrapped[W-1] != a[W-1]);
    else   w.o = (a[W-1] == b[W-1]) && (wrapped[W-1] != a[W-1]);
    w.res = wrapped;
`ifdef SERIAL_ADDSUB_SAT_EN
    if (w.o) w.res = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    w.cyc = cyc + W + ((stall_at >= 0) ? stall_len : 0);
    if (abort_at < 0) begin
      wq.push_back(w);
      n_words++;
    end
    for (int i = 0; i < W; i++) begin
      if (i == abort_at) begin
        start    = 1'b0;
        in1      = a[i];
        in2      = b[i];
        in_valid = 1'b1;
        checkOutput("busy_mid_word", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_flags", {26'd0, sum_bit, sum_valid, busy, done, cout, ovf}, 32'd0);
        checkOutput("async_reset_result", {24'd0, result}, 32'd0);
        bq.delete();
        in_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        return;
      end
      start    = (i == 0) || (midstart && i == 4);
      sub      = (i == 0) ? s : ~s;
      in1      = a[i];
      in2      = b[i];
      in_valid = 1'b1;
      bq.push_back(wrapped[i]);
      @(posedge clk); #1;
      if (i == stall_at) begin
        start    = 1'b0;
        in_valid = 1'b0;
        in1      = ~in1;
        repeat (stall_len) begin
          @(posedge clk); #1;
        end
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    start    = 1'b0;
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    cyc      = 0;
    n_words  = 0;
    n_done   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    sub      = 1'b0;
    in_valid = 1'b0;
    in1      = 1'b0;
    in2      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_flags", {26'd0, sum_bit, sum_valid, busy, done, cout, ovf}, 32'd0);
    checkOutput("reset_result", {24'd0, result}, 32'd0);
    rst_n = 1'b1;
    idleCycles(2);

    // Start without in_valid must not leave IDLE.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("start_no_valid_busy", {31'd0, busy}, 32'd0);
    idleCycles(1);

    $display("[TB] basic add and subtract");
    applyStimulus(8'h35, 8'h4A, 1'b0, -1, 0, 1'b0, -1);
    idleCycles(2);
    applyStimulus(8'h10, 8'h01, 1'b1, -1, 0, 1'b0, -1);
    idleCycles(1);
    applyStimulus(8'h01, 8'h02, 1'b1, -1, 0, 1'b0, -1);
    idleCycles(2);

    $display("[TB] signed overflow");
    applyStimulus(8'h7F, 8'h01, 1'b0, -1, 0, 1'b0, -1);
    idleCycles(1);
    applyStimulus(8'h80, 8'hFF, 1'b0, -1, 0, 1'b0, -1);
    idleCycles(2);

    $display("[TB] stall after bit 3");
    applyStimulus(8'h35, 8'h4A, 1'b0, 3, 3, 1'b0, -1);
    idleCycles(2);

    $display("[TB] reset mid-word");
    applyStimulus(8'h35, 8'h4A, 1'b0, -1, 0, 1'b0, 4);
    idleCycles(12);
    applyStimulus(8'h01, 8'h01, 1'b0, -1, 0, 1'b0, -1);
    idleCycles(2);

    $display("[TB] back-to-back with mid-word start");
    applyStimulus(8'h0F, 8'h01, 1'b0, -1, 0, 1'b1, -1);
    applyStimulus(8'h20, 8'h10, 1'b1, -1, 0, 1'b1, -1);
    applyStimulus(8'hC3, 8'h5A, 1'b1, 2, 1, 1'b0, -1);

    for (int k = 0; k < 50 && (wq.size() != 0 || bq.size() != 0); k++) begin
      @(posedge clk); #1;
    end
    idleCycles(3);
    checkOutput("drain_words", wq.size(), 32'd0);
    checkOutput("drain_bits", bq.size(), 32'd0);
    checkOutput("done_count", n_done, n_words);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
